rx_fifo: RTL and testbench

Receive-side buffer placed directly downstream of the UART receive module. Captures each received character and its parity-error flag on the receiver's one-cycle done pulse, and holds them in a synchronous circular FIFO. The FIFO is drained by the host/register interface through a read-request/valid handshake. Full, empty, occupancy and sticky overflow/underflow status are provided for the register map and interrupt logic.

---
 rtl/rx_fifo_if.sv | 33 +++
 rtl/rx_fifo.sv | 102 ++++++++++
 tb/tb_rx_fifo.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/rx_fifo_if.sv
// Receive FIFO bundle: write side from the UART receiver, read/status side to the register map.
// The master drives strobes and data; the slave (rx_fifo) returns registered read data and status.
interface rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  wr_perr_i;
    logic                  rd_en_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_perr_o;
    logic                  rd_valid_o;
    logic                  flush_i;
    logic                  clr_flags_i;
    logic                  empty_o;
    logic                  full_o;
    logic [DEPTH_LOG2:0]   count_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport slave (
        input  wr_en_i, wr_data_i, wr_perr_i, rd_en_i, flush_i, clr_flags_i,
        output rd_data_o, rd_perr_o, rd_valid_o, empty_o, full_o, count_o,
        output overflow_o, underflow_o
    );

    modport master (
        output wr_en_i, wr_data_i, wr_perr_i, rd_en_i, flush_i, clr_flags_i,
        input  rd_data_o, rd_perr_o, rd_valid_o, empty_o, full_o, count_o,
        input  overflow_o, underflow_o
    );
endinterface

// File: rtl/rx_fifo.sv
// Circular receive FIFO storing {parity_err, data}; pops return data one cycle after rd_en_i.
// Writes at full are dropped (sticky overflow) unless a pop happens the same cycle; reads at empty set underflow.
module rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input logic       clk_i,
    input logic       rst_i,
    rx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

    typedef logic [DATA_WIDTH:0] entry_t;

    entry_t                mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  empty_q, empty_d, full_q, full_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_perr_q, rd_perr_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  wr_acc, rd_acc;
    entry_t                rd_entry;

    always_comb begin
        rd_acc   = bus.rd_en_i && !empty_q && !bus.flush_i;
        // A pop frees the slot this edge, so a write at full still lands.
        wr_acc   = bus.wr_en_i && (!full_q || rd_acc) && !bus.flush_i;
        rd_entry = mem_q[rd_ptr_q];

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_perr_d  = rd_perr_q;
        rd_valid_d = rd_acc;

        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) begin
                rd_ptr_d  = rd_ptr_q + PTR_ONE;
                rd_data_d = rd_entry[DATA_WIDTH-1:0];
                rd_perr_d = rd_entry[DATA_WIDTH];
            end
            if (wr_acc && !rd_acc)      count_d = count_q + CNT_ONE;
            else if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_CNT);
        ovf_d   = (bus.wr_en_i && full_q && !rd_acc && !bus.flush_i) || (ovf_q && !bus.clr_flags_i);
        udf_d   = (bus.rd_en_i && empty_q && !bus.flush_i) || (udf_q && !bus.clr_flags_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_perr_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rd_data_q  <= rd_data_d;
            rd_perr_q  <= rd_perr_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Storage is not reset; pointers and count define what is live.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_acc) mem_q[wr_ptr_q] <= {bus.wr_perr_i, bus.wr_data_i};
    end

    assign bus.rd_data_o   = rd_data_q;
    assign bus.rd_perr_o   = rd_perr_q;
    assign bus.rd_valid_o  = rd_valid_q;
    assign bus.empty_o     = empty_q;
    assign bus.full_o      = full_q;
    assign bus.count_o     = count_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.underflow_o = udf_q;
endmodule

// File: tb/tb_rx_fifo.sv
// Directed scenarios plus randomized traffic for rx_fifo, checked against a queue-based reference.
module tb_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [8:0] m_q[$];
    logic [7:0] m_rd_data = '0;
    logic       m_rd_perr = 1'b0;
    logic       m_rv = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    rx_fifo_if #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) bus ();

    rx_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance one edge, update the reference, settle.
    task automatic step(input logic wr, input logic [7:0] d, input logic pe, input logic rd,
                        input logic fl, input logic cl, input logic rs);
        int         sz;
        logic       rd_ok, wr_ok;
        logic [8:0] e;
        bus.wr_en_i = wr; bus.wr_data_i = d; bus.wr_perr_i = pe; bus.rd_en_i = rd;
        bus.flush_i = fl; bus.clr_flags_i = cl; rst = rs;
        @(posedge clk);
        sz = m_q.size();
        if (rs) begin
            m_q.delete(); m_rd_data = '0; m_rd_perr = 1'b0; m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else if (fl) begin
            m_q.delete(); m_rv = 1'b0;
            if (cl) begin m_ovf = 1'b0; m_udf = 1'b0; end
        end else begin
            rd_ok = rd && (sz > 0);
            wr_ok = wr && ((sz < 16) || rd_ok);
            m_ovf = (wr && !wr_ok) || (m_ovf && !cl);
            m_udf = (rd && sz == 0) || (m_udf && !cl);
            if (rd_ok) begin
                e = m_q.pop_front();
                m_rd_data = e[7:0];
                m_rd_perr = e[8];
            end
            m_rv = rd_ok;
            if (wr_ok) m_q.push_back({pe, d});
        end
        #1;
    endtask

    task automatic test_reset;
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        total++; if (bus.rd_data_o !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%0h want=0", bus.rd_data_o); end
        total++; if (bus.rd_perr_o !== 1'b0) begin bad++; $display("FAIL reset_rd_perr got=%0b want=0", bus.rd_perr_o); end
        total++; if (bus.rd_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b want=0", bus.rd_valid_o); end
        total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b want=1", bus.empty_o); end
        total++; if (bus.full_o !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b want=0", bus.full_o); end
        total++; if (bus.count_o !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count_o); end
        total++; if ({bus.overflow_o, bus.underflow_o} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%0b want=00", {bus.overflow_o, bus.underflow_o}); end
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_basic;
        step(1, 8'hA5, 0, 0, 0, 0, 0);
        total++; if (bus.count_o !== 5'd1 || bus.empty_o !== 1'b0) begin bad++; $display("FAIL basic_wr_count got=%0d/%0b want=1/0", bus.count_o, bus.empty_o); end
        step(1, 8'h3C, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        total++; if ({bus.rd_valid_o, bus.rd_perr_o, bus.rd_data_o} !== {1'b1, 1'b0, 8'hA5}) begin bad++; $display("FAIL basic_rd1 got=%0b/%0b/%0h want=1/0/a5", bus.rd_valid_o, bus.rd_perr_o, bus.rd_data_o); end
        step(0, 0, 0, 1, 0, 0, 0);
        total++; if ({bus.rd_valid_o, bus.rd_perr_o, bus.rd_data_o} !== {1'b1, 1'b1, 8'h3C}) begin bad++; $display("FAIL basic_rd2 got=%0b/%0b/%0h want=1/1/3c", bus.rd_valid_o, bus.rd_perr_o, bus.rd_data_o); end
        total++; if (bus.empty_o !== 1'b1 || bus.count_o !== 5'd0) begin bad++; $display("FAIL basic_empty got=%0b/%0d want=1/0", bus.empty_o, bus.count_o); end
        step(0, 0, 0, 0, 0, 0, 0);
        total++; if (bus.rd_valid_o !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%0b want=0", bus.rd_valid_o); end
    endtask

    task automatic test_full_overflow;
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, 0, 0);
        total++; if (bus.full_o !== 1'b1 || bus.count_o !== 5'd16) begin bad++; $display("FAIL full_state got=%0b/%0d want=1/16", bus.full_o, bus.count_o); end
        total++; if (bus.overflow_o !== 1'b0) begin bad++; $display("FAIL full_no_ovf got=%0b want=0", bus.overflow_o); end
        step(1, 8'hFF, 0, 0, 0, 0, 0);
        total++; if (bus.overflow_o !== 1'b1 || bus.count_o !== 5'd16) begin bad++; $display("FAIL ovf_set got=%0b/%0d want=1/16", bus.overflow_o, bus.count_o); end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 1, 0, 0, 0);
            total++; if (bus.rd_valid_o !== 1'b1 || bus.rd_data_o !== 8'(i)) begin bad++; $display("FAIL drain_%0d got=%0b/%0h want=1/%0h", i, bus.rd_valid_o, bus.rd_data_o, i); end
        end
        total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b want=1", bus.empty_o); end
    endtask

    task automatic test_underflow;
        step(0, 0, 0, 1, 0, 0, 0);
        total++; if (bus.underflow_o !== 1'b1 || bus.rd_valid_o !== 1'b0) begin bad++; $display("FAIL udf_set got=%0b/%0b want=1/0", bus.underflow_o, bus.rd_valid_o); end
        total++; if (bus.rd_data_o !== 8'h0F) begin bad++; $display("FAIL udf_data_hold got=%0h want=0f", bus.rd_data_o); end
        step(0, 0, 0, 0, 0, 1, 0);
        total++; if ({bus.overflow_o, bus.underflow_o} !== 2'b00) begin bad++; $display("FAIL clr_flags got=%0b want=00", {bus.overflow_o, bus.underflow_o}); end
        step(0, 0, 0, 1, 0, 1, 0);
        total++; if (bus.underflow_o !== 1'b1) begin bad++; $display("FAIL clr_vs_set got=%0b want=1", bus.underflow_o); end
        step(0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_simul_full;
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, 0, 0);
        step(1, 8'h55, 0, 1, 0, 0, 0);
        total++; if (bus.rd_valid_o !== 1'b1 || bus.rd_data_o !== 8'h00) begin bad++; $display("FAIL simul_rd got=%0b/%0h want=1/0", bus.rd_valid_o, bus.rd_data_o); end
        total++; if (bus.count_o !== 5'd16 || bus.full_o !== 1'b1 || bus.overflow_o !== 1'b0) begin bad++; $display("FAIL simul_state got=%0d/%0b/%0b want=16/1/0", bus.count_o, bus.full_o, bus.overflow_o); end
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 0, 1, 0, 0, 0);
            total++; if (bus.rd_data_o !== ((i == 16) ? 8'h55 : 8'(i))) begin bad++; $display("FAIL wrap_%0d got=%0h", i, bus.rd_data_o); end
        end
    endtask

    task automatic test_back_to_back;
        step(1, 8'h11, 0, 0, 0, 0, 0);
        step(1, 8'h22, 1, 1, 0, 0, 0);
        total++; if (bus.rd_data_o !== 8'h11 || bus.count_o !== 5'd1) begin bad++; $display("FAIL cnt1_simul got=%0h/%0d want=11/1", bus.rd_data_o, bus.count_o); end
        step(1, 8'h33, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        total++; if ({bus.rd_valid_o, bus.rd_perr_o, bus.rd_data_o} !== {1'b1, 1'b1, 8'h22}) begin bad++; $display("FAIL b2b_1 got=%0b/%0b/%0h want=1/1/22", bus.rd_valid_o, bus.rd_perr_o, bus.rd_data_o); end
        step(0, 0, 0, 1, 0, 0, 0);
        total++; if ({bus.rd_valid_o, bus.rd_data_o} !== {1'b1, 8'h33}) begin bad++; $display("FAIL b2b_2 got=%0b/%0h want=1/33", bus.rd_valid_o, bus.rd_data_o); end
        step(0, 0, 0, 0, 0, 0, 0);
        total++; if (bus.rd_valid_o !== 1'b0 || bus.empty_o !== 1'b1) begin bad++; $display("FAIL b2b_end got=%0b/%0b want=0/1", bus.rd_valid_o, bus.empty_o); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0, 0, 0, 0);
        step(1, 8'h99, 0, 0, 1, 0, 0);
        total++; if (bus.count_o !== 5'd0 || bus.empty_o !== 1'b1) begin bad++; $display("FAIL flush_state got=%0d/%0b want=0/1", bus.count_o, bus.empty_o); end
        total++; if (bus.rd_data_o !== 8'h33 || bus.rd_valid_o !== 1'b0) begin bad++; $display("FAIL flush_hold got=%0h/%0b want=33/0", bus.rd_data_o, bus.rd_valid_o); end
        step(0, 0, 0, 1, 1, 0, 0);
        total++; if (bus.underflow_o !== 1'b0) begin bad++; $display("FAIL flush_no_udf got=%0b want=0", bus.underflow_o); end
        step(1, 8'h77, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        total++; if ({bus.rd_valid_o, bus.rd_data_o} !== {1'b1, 8'h77}) begin bad++; $display("FAIL flush_after got=%0b/%0h want=1/77", bus.rd_valid_o, bus.rd_data_o); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 8; i++) step(1, 8'(8'hC0 + i), 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 8'hEE, 1, 1, 0, 0, 1);
        total++; if ({bus.rd_valid_o, bus.rd_perr_o, bus.rd_data_o} !== 10'h000) begin bad++; $display("FAIL rstmid_rd got=%0b/%0b/%0h want=0/0/0", bus.rd_valid_o, bus.rd_perr_o, bus.rd_data_o); end
        total++; if ({bus.empty_o, bus.full_o, bus.count_o, bus.overflow_o, bus.underflow_o} !== {1'b1, 1'b0, 5'd0, 2'b00}) begin bad++; $display("FAIL rstmid_status got=%0b/%0b/%0d/%0b/%0b want=1/0/0/0/0", bus.empty_o, bus.full_o, bus.count_o, bus.overflow_o, bus.underflow_o); end
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random;
        logic [18:0] got, exp;
        int          wr_pct;
        for (int c = 0; c < 1200; c++) begin
            // Alternate write-heavy and read-heavy phases so full and empty are both visited.
            wr_pct = ((c / 60) % 2 == 0) ? 80 : 25;
            step(($urandom_range(0, 99) < wr_pct), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 99) < (105 - wr_pct)), ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 4), ($urandom_range(0, 299) == 0));
            got = {bus.rd_valid_o, bus.rd_perr_o, bus.rd_data_o, bus.empty_o, bus.full_o,
                   bus.count_o, bus.overflow_o, bus.underflow_o};
            exp = {m_rv, m_rd_perr, m_rd_data, (m_q.size() == 0), (m_q.size() == 16),
                   5'(m_q.size()), m_ovf, m_udf};
            total++; if (got !== exp) begin bad++; $display("FAIL random_cycle_%0d got=%05h want=%05h", c, got, exp); end
        end
    endtask

    initial begin
        bus.wr_en_i = 0; bus.wr_data_i = '0; bus.wr_perr_i = 0; bus.rd_en_i = 0;
        bus.flush_i = 0; bus.clr_flags_i = 0;
        test_reset();
        test_basic();
        test_full_overflow();
        test_underflow();
        test_simul_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
